// File: rtl/imem_load_ctrl.sv
// Instruction-RAM front end: passes CPU fetches through, or holds the CPU while a
// little-endian byte stream is packed into 32-bit words and written to the RAM.
module imem_load_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   pc,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic                    cpu_hold,
    input  logic                    load_start,
    input  logic [DEPTH_LOG2:0]     load_len,
    input  logic                    load_abort,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    byte_ready,
    output logic [DEPTH_LOG2-1:0]   mem_raddr,
    input  logic [INSTR_WIDTH-1:0]  mem_rdata,
    output logic                    mem_we,
    output logic [DEPTH_LOG2-1:0]   mem_waddr,
    output logic [INSTR_WIDTH-1:0]  mem_wdata,
    output logic                    load_done,
    output logic                    load_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [DEPTH_LOG2:0]    MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [INSTR_WIDTH-1:0] NOP     = INSTR_WIDTH'(32'h0000_0013);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [DEPTH_LOG2:0]      r_len;
    logic [DEPTH_LOG2:0]      r_ptr;
    logic [1:0]               r_cnt;
    logic [7:0]               r_bytes [3];
    logic                     r_mem_we;
    logic [DEPTH_LOG2-1:0]    r_mem_waddr;
    logic [INSTR_WIDTH-1:0]   r_mem_wdata;
    logic                     r_load_err;

    logic w_in_load;
    logic w_last_write;
    logic w_accept;
    logic w_word_done;
    logic w_start_ok;
    logic w_start_bad;
    logic w_unused;

    // PC bits outside the word index are intentionally ignored.
    assign w_unused  = ^{pc[ADDR_WIDTH-1:DEPTH_LOG2+2], pc[1:0]};
    assign mem_raddr = pc[DEPTH_LOG2+1:2];
    assign instr     = cpu_hold ? NOP : mem_rdata;
    assign mem_we    = r_mem_we;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;
    assign load_err  = r_load_err;

    assign w_in_load    = (r_state == ST_LOAD);
    // r_ptr already counts the word being written, so equality means final word.
    assign w_last_write = w_in_load && r_mem_we && (r_ptr == r_len);
    assign w_accept     = byte_ready && byte_valid && !load_abort;
    assign w_word_done  = w_accept && (r_cnt == 2'd3);
    assign w_start_ok   = (r_state == ST_RUN) && load_start && (load_len <= MAX_LEN);
    assign w_start_bad  = (r_state == ST_RUN) && load_start && (load_len > MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cpu_hold     = 1'b0;
        byte_ready   = 1'b0;
        load_done    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_start_ok) begin
                    w_state_next = (load_len == '0) ? ST_FLUSH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                cpu_hold   = 1'b1;
                byte_ready = !w_last_write;
                if (load_abort) begin
                    w_state_next = ST_RUN;
                end else if (w_last_write) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cpu_hold     = 1'b1;
                load_done    = 1'b1;
                w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_load_err  <= 1'b0;
            for (int b = 0; b < 3; b++) begin
                r_bytes[b] <= '0;
            end
        end else begin
            r_mem_we   <= w_word_done;
            r_load_err <= w_start_bad || (w_in_load && load_abort);
            if (w_start_ok) begin
                r_len <= load_len;
                r_ptr <= '0;
                r_cnt <= '0;
            end
            if (w_in_load && load_abort) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 2'd1;
                for (int b = 0; b < 3; b++) begin
                    if (r_cnt == 2'(b)) begin
                        r_bytes[b] <= byte_data;
                    end
                end
            end
            if (w_word_done) begin
                r_mem_waddr <= r_ptr[DEPTH_LOG2-1:0];
                r_mem_wdata <= INSTR_WIDTH'({byte_data, r_bytes[2], r_bytes[1], r_bytes[0]});
                r_ptr       <= r_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: stimulus pushes expected writes/pulses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_imem_load_ctrl;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int DL = 8;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          cpu_hold;
    logic          load_start;
    logic [DL:0]   load_len;
    logic          load_abort;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [DL-1:0] mem_raddr;
    logic [IW-1:0] mem_rdata;
    logic          mem_we;
    logic [DL-1:0] mem_waddr;
    logic [IW-1:0] mem_wdata;
    logic          load_done;
    logic          load_err;

    always #5 clk = ~clk;

    imem_load_ctrl #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .cpu_hold(cpu_hold),
        .load_start(load_start), .load_len(load_len), .load_abort(load_abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .load_done(load_done), .load_err(load_err)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_evt[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [DL:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gap);
        int waited = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        while (!byte_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!byte_ready) begin
            check("byte_ready_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
            return;
        end
        tick();
        byte_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8], gap);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!load_done && n < 20) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 32'(load_done), 32'd1);
        check({name, "_hold_in_flush"}, 32'(cpu_hold), 32'd1);
        tick();
        check({name, "_hold_released"}, 32'(cpu_hold), 32'd0);
        $display("txn %s: load completed", name);
    endtask

    // Monitor: every negedge, compare fetch path and pop scoreboard on any event.
    always @(negedge clk) begin
        wr_t e;
        int  code;
        check("mem_raddr", 32'(mem_raddr), 32'(pc[DL+1:2]));
        if (cpu_hold) check("instr_nop", instr, 32'h0000_0013);
        else          check("instr_pass", instr, mem_rdata);
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write",
                         mem_waddr, mem_wdata);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_waddr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
                $display("txn write: addr %0d data 0x%08h", mem_waddr, mem_wdata);
            end
        end
        if (load_done || load_err) begin
            code = (load_done ? EV_DONE : 0) + (load_err ? EV_ERR : 0);
            if (exp_evt.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got code %0d, required none", code);
            end else begin
                check("pulse_kind", 32'(code), 32'(exp_evt.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst_n      = 1'b0;
        pc         = 32'h8;
        mem_rdata  = 32'hDEAD_BEEF;
        load_start = 1'b0;
        load_len   = '0;
        load_abort = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        #2;
        check("rst_raddr", 32'(mem_raddr), 32'd2);
        check("rst_instr", instr, 32'hDEAD_BEEF);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_pulses", 32'({load_done, load_err}), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        $display("txn reset: checked");
        tick();
        tick();
        rst_n = 1'b1;
        pc    = 32'h1234;
        tick();

        // Two-word load, back-to-back bytes.
        exp_wr.push_back('{addr: 8'd0, data: 32'h0050_0513});
        exp_wr.push_back('{addr: 8'd1, data: 32'h0010_0593});
        exp_evt.push_back(EV_DONE);
        start_load(9'd2);
        check("load_hold", 32'(cpu_hold), 32'd1);
        send_word(32'h0050_0513, 1'b0);
        send_word(32'h0010_0593, 1'b0);
        wait_done("b2b_len2");

        // Same load with byte_valid toggling.
        exp_wr.push_back('{addr: 8'd0, data: 32'h0050_0513});
        exp_wr.push_back('{addr: 8'd1, data: 32'h0010_0593});
        exp_evt.push_back(EV_DONE);
        start_load(9'd2);
        send_word(32'h0050_0513, 1'b1);
        send_word(32'h0010_0593, 1'b1);
        wait_done("toggle_len2");

        // Oversized request is rejected.
        exp_evt.push_back(EV_ERR);
        start_load(9'd257);
        check("len257_err", 32'(load_err), 32'd1);
        check("len257_hold", 32'(cpu_hold), 32'd0);
        check("len257_ready", 32'(byte_ready), 32'd0);
        tick();
        tick();
        $display("txn len257: rejected");

        // Abort after six bytes of a three-word load.
        exp_wr.push_back('{addr: 8'd0, data: 32'hCAFE_F00D});
        exp_evt.push_back(EV_ERR);
        start_load(9'd3);
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        check("abort_hold", 32'(cpu_hold), 32'd0);
        check("abort_ready", 32'(byte_ready), 32'd0);
        check("abort_err", 32'(load_err), 32'd1);
        $display("txn abort: load abandoned");
        tick();
        exp_wr.push_back('{addr: 8'd0, data: 32'h0102_0304});
        exp_evt.push_back(EV_DONE);
        start_load(9'd1);
        send_word(32'h0102_0304, 1'b0);
        wait_done("restart_len1");

        // Full-depth load.
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(255 - i), 8'h5A, 8'(i * 3)};
            exp_wr.push_back('{addr: 8'(i), data: w});
        end
        exp_evt.push_back(EV_DONE);
        start_load(9'd256);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(255 - i), 8'h5A, 8'(i * 3)};
            send_word(w, 1'b0);
        end
        wait_done("full_len256");

        // Zero-length load goes straight to flush.
        exp_evt.push_back(EV_DONE);
        start_load(9'd0);
        wait_done("len0");

        // Reset while a write is being presented.
        start_load(9'd4);
        send_word(32'h5566_7788, 1'b0);
        check("prerst_we", 32'(mem_we), 32'd1);
        check("prerst_hold", 32'(cpu_hold), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);
        check("midrst_waddr", 32'(mem_waddr), 32'd0);
        $display("txn reset_mid_load: outputs cleared");
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        check("scoreboard_writes_left", 32'(exp_wr.size()), 32'd0);
        check("scoreboard_pulses_left", 32'(exp_evt.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller in front of the single-port-write / async-read instruction RAM of the core.
- In normal operation it forwards fetch reads from the PC.
- On request it receives a program as a byte stream, packs the bytes little-endian into 32-bit words and writes them to the RAM. The CPU is held (stalled, fed NOPs) for the whole load.
- This lets firmware be reloaded without re-elaborating the hex image.

Parameters:
- ADDR_WIDTH, 32, width of the CPU PC.
- INSTR_WIDTH, 32, instruction/word width (fixed at 32; 4 bytes per word).
- DEPTH_LOG2, 8, log2 of RAM depth in words (256 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  ADDR_WIDTH  CPU fetch address (byte address).
- instr  out  INSTR_WIDTH  instruction to CPU.
- cpu_hold  out  1  stall/hold CPU while high.
- load_start  in  1  single-cycle request to begin a load.
- load_len  in  DEPTH_LOG2+1  number of words to load; sampled with load_start.
- load_abort  in  1  abandon an in-progress load.
- byte_valid  in  1  stream byte valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  controller accepts byte this cycle.
- mem_raddr  out  DEPTH_LOG2  RAM read word index.
- mem_rdata  in  INSTR_WIDTH  RAM async read data.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  DEPTH_LOG2  RAM write word index.
- mem_wdata  out  INSTR_WIDTH  RAM write data.
- load_done  out  1  one-cycle pulse on successful completion.
- load_err  out  1  one-cycle pulse on rejected or aborted load.

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state RUN; cpu_hold 0, byte_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, load_done 0, load_err 0; word pointer 0, byte counter 0.
- mem_raddr = pc[DEPTH_LOG2+1:2], always combinational. PC bits [1:0] are ignored.
- instr = cpu_hold ? 32'h00000013 (NOP) : mem_rdata, combinational.

RUN state:
- cpu_hold 0, byte_ready 0.
- load_start with load_len <= 2**DEPTH_LOG2:
  - latch load_len;
  - clear word pointer and byte counter;
  - go to LOAD next cycle.
- load_start with load_len > 2**DEPTH_LOG2: stay in RUN, pulse load_err the next cycle, no write.
- load_start with load_len == 0: go to FLUSH directly, no writes.

LOAD state:
- cpu_hold 1, byte_ready 1.
- A byte is accepted when byte_valid & byte_ready. Byte k (k = 0..3) of a word goes to bits [8k+7:8k].
- On the 4th accepted byte, the next cycle has:
  - mem_we = 1 for exactly one cycle;
  - mem_waddr = word pointer;
  - mem_wdata = the assembled word.
  The word pointer then increments and the byte counter wraps to 0.
- byte_ready stays 1 during that write cycle; streaming is back-to-back with no bubbles.
- When the write of word load_len-1 issues: byte_ready drops in the same cycle; go to FLUSH next cycle.
- load_abort has priority over byte acceptance in the same cycle:
  - go to RUN next cycle with load_err pulsed;
  - a write already registered still completes;
  - previously written words stay in RAM;
  - partial bytes are discarded.
- load_start while in LOAD is ignored.

FLUSH state:
- One cycle, cpu_hold 1, byte_ready 0, load_done 1.
- Next cycle: RUN. The CPU sees real instructions from that cycle.

Reset mid-load:
- Immediately returns to RUN with all outputs at reset values.
- RAM contents are undefined, not cleared.

Word pointer: DEPTH_LOG2+1 bits, so load_len == 2**DEPTH_LOG2 completes without aliasing. mem_waddr uses the low DEPTH_LOG2 bits.

Test Plan:
- Reset, pc=0x8, mem_rdata=0xDEADBEEF → mem_raddr=2, instr=0xDEADBEEF, cpu_hold=0, all pulses 0.
- load_start, load_len=2, bytes 0x13,0x05,0x50,0x00,0x93,0x05,0x10,0x00 back-to-back:
  - mem_we pulses with (0, 0x00500513) then (1, 0x00100593);
  - instr=0x00000013 throughout;
  - load_done pulses once;
  - cpu_hold falls the cycle after load_done.
- Same load with byte_valid toggling 1/0 every cycle → same two writes, one cycle after each 4th byte; no extra writes.
- load_len=257 (DEPTH_LOG2=8) → load_err pulse, state stays RUN, mem_we never asserted, cpu_hold 0.
- load_len=3, abort after 6 bytes:
  - word 0 written;
  - load_err pulses, no load_done;
  - cpu_hold 0 from the next cycle;
  - next load_start restarts at waddr 0.
- load_len=256 full stream → last write waddr=255; load_done pulses. Also load_len=0 → load_done with no mem_we. Also rst_n low mid-load → cpu_hold, mem_we, byte_ready go 0 asynchronously.
